// File: rtl/agp32_mem_pkg.sv
// Shared types and constants for the agp32 memory controller.
package agp32_mem_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_FETCH     = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_INTERRUPT = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FETCH = 3'd3,
    ST_HALT  = 3'd4
  } mc_state_t;

  // Instruction word presented before the first fetch completes.
  localparam logic [31:0] NOP_INSTR = 32'd63;

  // States that drive a backend request.
  function automatic logic is_req_state(input mc_state_t s);
    return (s == ST_DATA) || (s == ST_FETCH);
  endfunction

endpackage

// File: rtl/agp32_mem_watchdog.sv
// Cycle counter: counts cycles with run=1, saturating at LIMIT.
// expired flags the LIMIT-th run cycle itself, so the caller can act on
// the same edge that ends it.
module agp32_mem_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Count run cycles; clear wins over run so a fresh request starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                            cnt <= '0;
    else if (clear)                        cnt <= '0;
    else if (run && (cnt != W'(LIMIT)))    cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/agp32_mem_ctrl.sv
// Memory controller between the agp32 processor and a single-port word
// memory. One command in flight; every command ends with an instruction
// (re)fetch before ready rises again.
module agp32_mem_ctrl
  import agp32_mem_pkg::*;
#(
  parameter int INIT_CYCLES = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  command,
  input  logic [31:0] PC,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic [31:0] inst_rdata,
  output logic [31:0] data_rdata,
  output logic [1:0]  error,
  output logic        mem_start_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  mc_state_t   state, state_n;
  logic        req_start;
  logic        init_done, to_expired;

  logic [29:0] pc_q, addr_q;
  logic [31:0] wdata_q, inst_q, data_q;
  logic [3:0]  wstrb_q;
  logic        wr_q;
  logic        fetched_q;
  err_t        err_q;

  // Byte offsets are dropped: the backend is word addressed.
  logic unused_lsbs;
  assign unused_lsbs = ^{PC[1:0], data_addr[1:0]};

  agp32_mem_watchdog #(.LIMIT(INIT_CYCLES)) u_init_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (1'b0),
    .run     (state == ST_INIT),
    .expired (init_done)
  );

  agp32_mem_watchdog #(.LIMIT(TIMEOUT)) u_req_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (req_start),
    .run     (mem_req),
    .expired (to_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_n;
  end

  // Next state; a backend ack beats a same-cycle timeout, and an error ack halts.
  always_comb begin
    state_n = state;
    case (state)
      ST_INIT:  if (init_done) state_n = ST_IDLE;
      ST_IDLE: begin
        case (cmd_t'(command))
          CMD_FETCH, CMD_INTERRUPT: state_n = ST_FETCH;
          CMD_READ, CMD_WRITE:      state_n = ST_DATA;
          default:                  state_n = ST_IDLE;
        endcase
      end
      ST_DATA: begin
        if (mem_ack)         state_n = mem_err ? ST_HALT : ST_FETCH;
        else if (to_expired) state_n = ST_HALT;
      end
      ST_FETCH: begin
        if (mem_ack)         state_n = mem_err ? ST_HALT : ST_IDLE;
        else if (to_expired) state_n = ST_HALT;
      end
      ST_HALT:  state_n = ST_HALT;
      default:  state_n = ST_INIT;
    endcase
    // Entering a request state (including DATA->FETCH) restarts the wait count.
    req_start = is_req_state(state_n) && (state_n != state);
  end

  // Backend and processor-facing outputs decoded from state and operands.
  always_comb begin
    mem_req         = is_req_state(state);
    mem_we          = (state == ST_DATA) && wr_q;
    mem_addr        = (state == ST_DATA) ? addr_q : pc_q;
    mem_wstrb       = mem_we ? wstrb_q : 4'hF;
    ready           = (state == ST_IDLE) && fetched_q;
    mem_start_ready = (state != ST_INIT);
  end

  assign mem_wdata  = wdata_q;
  assign inst_rdata = inst_q;
  assign data_rdata = data_q;
  assign error      = err_q;

  // Operand capture at acceptance, read-data return and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_q      <= 1'b0;
      inst_q    <= NOP_INSTR;
      data_q    <= '0;
      fetched_q <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      if ((state == ST_IDLE) && req_start) begin
        pc_q    <= PC[31:2];
        addr_q  <= data_addr[31:2];
        wdata_q <= data_wdata;
        wstrb_q <= data_wstrb;
        wr_q    <= (cmd_t'(command) == CMD_WRITE);
      end
      if (mem_req && mem_ack) begin
        if (mem_err) begin
          err_q <= ERR_BUS;
        end else if (state == ST_FETCH) begin
          inst_q    <= mem_rdata;
          fetched_q <= 1'b1;
        end else if (!wr_q) begin
          data_q <= mem_rdata;
        end
      end else if (mem_req && to_expired) begin
        err_q <= ERR_TIMEOUT;
      end
    end
  end

endmodule
